// File: rtl/cpu8_ram_pkg.sv
// Shared constants and FSM encoding for the program RAM arbiter.
package cpu8_ram_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    // LOAD is the reset state: the loader owns the RAM port until the boot phase ends.
    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        IDLE     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        WR       = 3'd4
    } state_e;

endpackage

// File: rtl/ram_load_cnt.sv
// Boot-phase write address and byte counter.
// The address saturates at the last word so it never wraps, while the count
// still advances to DEPTH so that a full load reports 64 bytes.
module ram_load_cnt #(
    parameter int ADDR_W = cpu8_ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   count,
    output logic              term
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;

    // Terminal flag: the current address is the last RAM word.
    assign term  = &addr_q;
    assign addr  = addr_q;
    assign count = count_q;

    // Next address/count: clear wins over increment; address holds at the top.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (clr) begin
            addr_d  = '0;
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
            if (!term) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_boot_arbiter.sv
// Program RAM port owner: boot loader phase followed by CPU req/ack access.
// RAM read data arrives one cycle after the address, so reads take an issue
// and a wait cycle; writes take a single cycle. Acks are registered pulses.
module ram_boot_arbiter #(
    parameter int ADDR_W = cpu8_ram_pkg::ADDR_W,
    parameter int DATA_W = cpu8_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // loader stream
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              ld_start,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    // CPU access
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    // RAM port
    output logic              ram_iwr,
    output logic              ram_edtb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    import cpu8_ram_pkg::*;

    state_e            state_q;
    state_e            state_d;
    logic              start_pend_q;
    logic              start_pend_d;
    logic              load_done_q;
    logic              load_done_d;
    logic              cpu_ack_q;
    logic              cpu_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [ADDR_W-1:0] req_addr_d;
    logic [DATA_W-1:0] req_wdata_q;
    logic [DATA_W-1:0] req_wdata_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_term;
    logic [ADDR_W-1:0] ld_addr;

    ram_load_cnt #(
        .ADDR_W (ADDR_W)
    ) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .addr  (ld_addr),
        .count (load_count),
        .term  (cnt_term)
    );

    assign load_done = load_done_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_hold  = (state_q == LOAD);

    // Next-state, request latch and RAM port mux. RAM strobes and ld_ready are
    // forced low while rst is high so nothing is written during reset.
    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        load_done_d  = load_done_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        ld_ready     = 1'b0;
        ram_iwr      = 1'b0;
        ram_edtb     = 1'b0;
        ram_addr     = '0;
        ram_din      = '0;

        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_iwr  = 1'b1;
                    ram_addr = ld_addr;
                    ram_din  = ld_data;
                    cnt_inc  = 1'b1;
                    if (ld_last || cnt_term) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            IDLE: begin
                // A boot request beats a CPU request; in the ack cycle the
                // still-asserted request belongs to the access just finished.
                if (start_pend_q || ld_start) begin
                    state_d      = LOAD;
                    start_pend_d = 1'b0;
                    load_done_d  = 1'b0;
                    cnt_clr      = 1'b1;
                end else if (cpu_req && !cpu_ack_q) begin
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = cpu_we ? WR : RD_ISSUE;
                end
            end
            WR: begin
                ram_iwr  = 1'b1;
                ram_addr = req_addr_q;
                ram_din  = req_wdata_q;
                state_d  = IDLE;
                cpu_ack_d = 1'b1;
                if (ld_start) begin
                    start_pend_d = 1'b1;
                end
            end
            RD_ISSUE: begin
                ram_edtb = 1'b1;
                ram_addr = req_addr_q;
                state_d  = RD_WAIT;
                if (ld_start) begin
                    start_pend_d = 1'b1;
                end
            end
            RD_WAIT: begin
                ram_edtb    = 1'b1;
                ram_addr    = req_addr_q;
                cpu_rdata_d = ram_dout;
                cpu_ack_d   = 1'b1;
                state_d     = IDLE;
                if (ld_start) begin
                    start_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (rst) begin
            ld_ready = 1'b0;
            ram_iwr  = 1'b0;
            ram_edtb = 1'b0;
            ram_addr = '0;
            ram_din  = '0;
        end
    end

    // State and datapath registers; reset aborts any access without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            start_pend_q <= 1'b0;
            load_done_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            load_done_q  <= load_done_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

endmodule
